operand_triplet_collector: RTL and testbench
============================================

Name: operand_triplet_collector

Overview:
Front-end feeder for the three-operand compute block. It accepts a serial byte stream under a valid/ready handshake and groups every three bytes into one parallel operand set (a, b, c). It presents that set on a registered output with its own valid/ready handshake. It also tracks frame alignment using a first-byte marker, flags resynchronisation events, and counts completed triplets.

Parameters:
DATA_W, 8, width of each operand byte/word
CNT_W, 16, width of the completed-triplet counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_data  input  DATA_W  serial input operand
s_first  input  1  marks s_data as operand a of a new triplet
s_valid  input  1  input word valid
s_ready  output  1  collector can accept s_data this cycle
m_a  output  DATA_W  operand a of the presented triplet
m_b  output  DATA_W  operand b
m_c  output  DATA_W  operand c
m_valid  output  1  triplet valid
m_ready  input  1  downstream accepts triplet
err_resync  output  1  one-cycle pulse: partial triplet discarded
trip_cnt  output  CNT_W  number of triplets loaded into output, wraps

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - state=S_A; a_q, b_q, m_a, m_b, m_c = 0.
  - m_valid=0, err_resync=0, trip_cnt=0.
  - s_ready reads 1 immediately after reset.
- Input accept is acc = s_valid & s_ready. Output transfer is xfer = m_valid & m_ready.
- FSM states are S_A (expect a), S_B (expect b), S_C (expect c).
  - S_A, on acc: a_q<=s_data; go to S_B. s_first is not required in S_A; it is ignored there.
  - S_B, on acc with s_first=0: b_q<=s_data; go to S_C.
  - S_C, on acc with s_first=0:
    - m_a<=a_q, m_b<=b_q, m_c<=s_data, m_valid<=1.
    - trip_cnt<=trip_cnt+1, mod 2^CNT_W.
    - Go to S_A.
  - S_B or S_C, on acc with s_first=1: discard the partial triplet; a_q<=s_data; go to S_B; err_resync<=1 on the next cycle, for exactly one cycle. The output register is untouched.
  - No acc: hold state and data.
- s_ready (combinational) = (state!=S_C) | ~m_valid | m_ready.
  - Stall occurs only when the third word would overwrite an undrained output.
  - A stalled S_C word carrying s_first=1 is still only accepted when s_ready=1. It then performs resync, not load.
- Latency: third word accepted in cycle N -> m_valid=1 with the data in cycle N+1.
- Output register:
  - m_valid clears on xfer when there is no load in the same cycle.
  - Simultaneous xfer and load: m_valid stays 1 and the new data replaces the old. This gives sustained throughput of one triplet per three input cycles with no bubble.
  - While m_valid & ~m_ready, m_a, m_b and m_c are stable.
- s_data is not sampled when acc=0. X on s_data with s_valid=0 must not propagate.
- Reset mid-triplet: partial data is lost; the next accepted word is operand a.

Decomposition:
- Shared package: state enum {S_A, S_B, S_C} (2-bit), default DATA_W/CNT_W constants.
- Sub-module triplet_out_reg: holds m_a, m_b, m_c and m_valid. It has a load/xfer interface and owns the simultaneous load/drain rule.
- The FSM, counter and error pulse stay in the top module.

Test Plan:
- Basic: m_ready=1; send 0x11(first), 0x22, 0x33 -> one cycle after 0x33 is accepted, m_a=0x11, m_b=0x22, m_c=0x33, m_valid=1 for 1 cycle; trip_cnt=1; err_resync never asserts.
- Backpressure: m_ready=0; send 0x01,0x02,0x03 then 0x04,0x05,0x06 -> the first triplet holds stable; s_ready=0 while 0x06 is pending in S_C. Raise m_ready -> 01/02/03 transfers, 04/05/06 loads the next cycle, trip_cnt=2.
- Resync: send 0x11(first), 0x22, 0x44(first), 0x55, 0x66 -> err_resync pulses once, the cycle after 0x44 is accepted; output is 0x44/0x55/0x66; trip_cnt=1.
- Back-to-back: m_ready=1; continuous s_valid with 9 words -> three triplets, m_valid never drops between a load and a concurrent xfer, s_ready stays 1.
- Reset mid-operation: accept 0xAA, 0xBB; assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, 0x01, 0x02, 0x03 -> triplet 01/02/03.
- Wrap: CNT_W=2; load 5 triplets -> trip_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/operand_triplet_collector_pkg.sv
// Shared types and default widths for the operand triplet collector.
package operand_triplet_collector_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Which operand of the current triplet the next accepted word fills.
    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2
    } state_t;

endpackage

// File: rtl/operand_triplet_collector_triplet_out_reg.sv
// Registered output stage holding one complete (a, b, c) triplet.
// A load always wins over a drain, so a triplet can be replaced in the
// same cycle the previous one is taken, with no bubble.
module triplet_out_reg
    import operand_triplet_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [DATA_W-1:0] o_c,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic              r_valid;

    // Operand registers change only on a load; held stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
            r_c <= i_c;
        end
    end

    // Valid sets on load, clears on a drain that has no concurrent load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_c     = r_c;
    assign o_valid = r_valid;

endmodule

// File: rtl/operand_triplet_collector.sv
// Groups a serial byte stream into (a, b, c) operand triplets, realigning
// on the first-byte marker and counting triplets handed to the output stage.
module operand_triplet_collector
    import operand_triplet_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_first,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_a,
    output logic [DATA_W-1:0] m_b,
    output logic [DATA_W-1:0] m_c,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              err_resync,
    output logic [CNT_W-1:0]  trip_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;
    logic [CNT_W-1:0]  r_trip_cnt;
    logic              r_err_resync;
    logic              w_m_valid;
    logic              w_acc;
    logic              w_cap_a;
    logic              w_cap_b;
    logic              w_load;
    logic              w_resync;

    // Only the third word can stall: it would overwrite an undrained triplet.
    assign s_ready = (r_state != S_C) | ~w_m_valid | m_ready;
    assign w_acc   = s_valid & s_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-word actions; a first marker mid-triplet restarts at b.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        w_load      = 1'b0;
        w_resync    = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_A: begin
                    w_cap_a     = 1'b1;
                    w_state_nxt = S_B;
                end
                S_B, S_C: begin
                    if (s_first) begin
                        w_cap_a     = 1'b1;
                        w_resync    = 1'b1;
                        w_state_nxt = S_B;
                    end else if (r_state == S_B) begin
                        w_cap_b     = 1'b1;
                        w_state_nxt = S_C;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_A;
                    end
                end
                default: begin
                    w_state_nxt = S_A;
                end
            endcase
        end
    end

    // Partial-triplet holding registers, written only on accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            if (w_cap_a) begin
                r_a_q <= s_data;
            end
            if (w_cap_b) begin
                r_b_q <= s_data;
            end
        end
    end

    // Triplet counter (wrapping) and single-cycle resync flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trip_cnt   <= '0;
            r_err_resync <= 1'b0;
        end else begin
            r_err_resync <= w_resync;
            if (w_load) begin
                r_trip_cnt <= r_trip_cnt + CNT_W'(1);
            end
        end
    end

    triplet_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_a     (r_a_q),
        .i_b     (r_b_q),
        .i_c     (s_data),
        .i_ready (m_ready),
        .o_a     (m_a),
        .o_b     (m_b),
        .o_c     (m_c),
        .o_valid (w_m_valid)
    );

    assign m_valid    = w_m_valid;
    assign err_resync = r_err_resync;
    assign trip_cnt   = r_trip_cnt;

endmodule

// File: tb/tb_operand_triplet_collector.sv
// Directed bench for operand_triplet_collector; a second instance with a
// 2-bit counter shares the stimulus to exercise counter wrap.
module tb_operand_triplet_collector;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_first;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_a, m_b, m_c;
    logic        m_valid;
    logic        m_ready;
    logic        err_resync;
    logic [15:0] trip_cnt;

    logic        w2_s_ready;
    logic [7:0]  w2_m_a, w2_m_b, w2_m_c;
    logic        w2_m_valid;
    logic        w2_err_resync;
    logic [1:0]  w2_trip_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    int e0;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    operand_triplet_collector #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_first(s_first),
        .s_valid(s_valid), .s_ready(s_ready), .m_a(m_a), .m_b(m_b), .m_c(m_c),
        .m_valid(m_valid), .m_ready(m_ready), .err_resync(err_resync),
        .trip_cnt(trip_cnt)
    );

    operand_triplet_collector #(.DATA_W(8), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_first(s_first),
        .s_valid(s_valid), .s_ready(w2_s_ready), .m_a(w2_m_a), .m_b(w2_m_b),
        .m_c(w2_m_c), .m_valid(w2_m_valid), .m_ready(m_ready),
        .err_resync(w2_err_resync), .trip_cnt(w2_trip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count resync pulses seen between clock edges.
    always @(negedge clk) begin
        if (rst_n && err_resync) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] d, input logic f);
        int n;
        n = 0;
        s_data  = d;
        s_first = f;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("send_timeout", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_trip(input string tag, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c);
        check({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
        check({tag, "_a"}, {24'b0, m_a}, {24'b0, a});
        check({tag, "_b"}, {24'b0, m_b}, {24'b0, b});
        check({tag, "_c"}, {24'b0, m_c}, {24'b0, c});
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #12;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_err", {31'b0, err_resync}, 32'd0);
        check("rst_cnt", {16'b0, trip_cnt}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);
        check("rst_m_a", {24'b0, m_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic triplet
        e0 = err_cnt;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check_trip("basic", 8'h11, 8'h22, 8'h33);
        check("basic_cnt", {16'b0, trip_cnt}, 32'd1);
        @(negedge clk);
        check("basic_drain", {31'b0, m_valid}, 32'd0);
        check("basic_err", err_cnt - e0, 32'd0);

        // Backpressure
        do_reset();
        m_ready = 1'b0;
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check_trip("bp_first", 8'h01, 8'h02, 8'h03);
        send(8'h04, 1'b1);
        send(8'h05, 1'b0);
        s_data  = 8'h06;
        s_first = 1'b0;
        s_valid = 1'b1;
        check("bp_stall0", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("bp_stall1", {31'b0, s_ready}, 32'd0);
        check_trip("bp_hold", 8'h01, 8'h02, 8'h03);
        check("bp_cnt1", {16'b0, trip_cnt}, 32'd1);
        m_ready = 1'b1;
        #1;
        check("bp_release", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check_trip("bp_second", 8'h04, 8'h05, 8'h06);
        check("bp_cnt2", {16'b0, trip_cnt}, 32'd2);
        @(negedge clk);
        check("bp_drain", {31'b0, m_valid}, 32'd0);

        // Resync from S_B
        do_reset();
        e0 = err_cnt;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h44, 1'b1);
        check("rs_pulse", {31'b0, err_resync}, 32'd1);
        send(8'h55, 1'b0);
        check("rs_pulse_end", {31'b0, err_resync}, 32'd0);
        send(8'h66, 1'b0);
        check_trip("rs_out", 8'h44, 8'h55, 8'h66);
        check("rs_cnt", {16'b0, trip_cnt}, 32'd1);
        check("rs_pulses", err_cnt - e0, 32'd1);

        // Resync from S_C
        send(8'h77, 1'b1);
        send(8'h88, 1'b0);
        send(8'h99, 1'b1);
        check("rsc_pulse", {31'b0, err_resync}, 32'd1);
        check("rsc_cnt", {16'b0, trip_cnt}, 32'd1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        check_trip("rsc_out", 8'h99, 8'hAA, 8'hBB);
        check("rsc_cnt2", {16'b0, trip_cnt}, 32'd2);

        // Back-to-back
        do_reset();
        for (int i = 0; i < 9; i++) begin
            s_data  = 8'(i + 1);
            s_first = (i % 3 == 0);
            s_valid = 1'b1;
            check("b2b_s_ready", {31'b0, s_ready}, 32'd1);
            @(negedge clk);
            if (i % 3 == 2) check_trip("b2b", 8'(i - 1), 8'(i), 8'(i + 1));
        end
        s_valid = 1'b0;
        check("b2b_cnt", {16'b0, trip_cnt}, 32'd3);

        // Asynchronous reset mid-operation
        do_reset();
        m_ready = 1'b0;
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", {31'b0, m_valid}, 32'd0);
        check("arst_m_a", {24'b0, m_a}, 32'd0);
        check("arst_cnt", {16'b0, trip_cnt}, 32'd0);
        check("arst_s_ready", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check_trip("arst_out", 8'h01, 8'h02, 8'h03);
        check("arst_cnt1", {16'b0, trip_cnt}, 32'd1);

        // Counter wrap on the 2-bit instance
        do_reset();
        for (int t = 0; t < 5; t++) begin
            send(8'(t * 3 + 1), 1'b1);
            send(8'(t * 3 + 2), 1'b0);
            send(8'(t * 3 + 3), 1'b0);
            check("wrap_cnt", {30'b0, w2_trip_cnt}, wrap_exp[t]);
            check("wide_cnt", {16'b0, trip_cnt}, 32'(t + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
